spi_slave_ctrl: RTL and testbench

- Parametrised full-duplex SPI slave, the successor to the fixed 8-bit, mode-0, receive-only interface.
- Adds configurable word width, CPOL/CPHA mode and bit order, plus a transmit path.
- Adds valid/ack receive handshake and transmit ready/valid handshake.
- Adds abort, overrun and underrun detection.
- Sits between the external MCU SPI pins and the FPGA register/command logic, all in the `clk` domain.

---
 rtl/spi_slave_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// ============================================================================
// Module   : spi_slave_ctrl
// Brief    : Parametrised full-duplex SPI slave with rx valid/ack and tx
//            ready/valid handshakes, abort/overrun/underrun detection.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_ctrl #(
    parameter int WORD_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ssel_,
    output logic              miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              underrun
);

    localparam int         c_CNT_W       = $clog2(WORD_W + 1);
    localparam logic       c_SCK_IDLE    = (CPOL != 0);
    localparam logic       c_SAMPLE_RISE = (CPOL == CPHA);
    localparam logic       c_MSB_FIRST   = (MSB_FIRST != 0);
    localparam logic [0:0] c_IDLE        = 1'b0;
    localparam logic [0:0] c_ACTIVE      = 1'b1;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_ssel_sync;
    logic                   r_sck_d, r_ssel_d;
    logic [0:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [WORD_W-1:0]      r_tx_shift, r_rx_shift, r_hold;
    logic                   r_hold_full, r_word_done;

    logic                   w_sck_s, w_mosi_s, w_ssel_s;
    logic                   w_sample, w_shift, w_ssel_fall, w_ssel_rise;
    logic [0:0]             w_state_nx;
    logic [c_CNT_W-1:0]     w_cnt_nx;
    logic [WORD_W-1:0]      w_tx_nx, w_rx_nx;
    logic                   w_load, w_done_nx, w_ferr_nx, w_tx_bit_nx, w_capture;

    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ssel_s    = r_ssel_sync[SYNC_STAGES-1];
    assign w_sample    = c_SAMPLE_RISE ? (w_sck_s & ~r_sck_d) : (~w_sck_s & r_sck_d);
    assign w_shift     = c_SAMPLE_RISE ? (~w_sck_s & r_sck_d) : (w_sck_s & ~r_sck_d);
    assign w_ssel_fall = ~w_ssel_s & r_ssel_d;
    assign w_ssel_rise = w_ssel_s & ~r_ssel_d;
    assign w_tx_bit_nx = c_MSB_FIRST ? w_tx_nx[WORD_W-1] : w_tx_nx[0];
    assign w_capture   = tx_valid & ~r_hold_full;
    assign busy        = (r_state == c_ACTIVE);
    assign tx_ready    = ~r_hold_full;

    // ssel_ syncs reset low so a select held low through reset never looks
    // like a fresh falling edge once reset is released.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sck_sync  <= {SYNC_STAGES{c_SCK_IDLE}};
            r_mosi_sync <= '0;
            r_ssel_sync <= '0;
            r_sck_d     <= c_SCK_IDLE;
            r_ssel_d    <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], ssel_};
            r_sck_d     <= w_sck_s;
            r_ssel_d    <= w_ssel_s;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tx_nx    = r_tx_shift;
        w_rx_nx    = r_rx_shift;
        w_load     = 1'b0;
        w_done_nx  = 1'b0;
        w_ferr_nx  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_ssel_fall) begin
                    w_state_nx = c_ACTIVE;
                    w_cnt_nx   = '0;
                    w_rx_nx    = '0;
                    w_load     = 1'b1;
                end
            end
            default: begin
                if (w_ssel_rise) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                    w_ferr_nx  = (r_cnt != '0) && !r_word_done;
                end else if (r_word_done) begin
                    w_cnt_nx = '0;
                    w_load   = 1'b1;
                end else if (w_sample) begin
                    w_rx_nx   = c_MSB_FIRST ? {r_rx_shift[WORD_W-2:0], w_mosi_s}
                                            : {w_mosi_s, r_rx_shift[WORD_W-1:1]};
                    w_cnt_nx  = r_cnt + c_CNT_W'(1);
                    w_done_nx = (r_cnt == c_CNT_W'(WORD_W - 1));
                end else if (w_shift && (r_cnt != '0)) begin
                    // A shift edge at count 0 is the one that would clobber the
                    // first bit of a freshly loaded word, so it is skipped.
                    w_tx_nx = c_MSB_FIRST ? {r_tx_shift[WORD_W-2:0], 1'b0}
                                          : {1'b0, r_tx_shift[WORD_W-1:1]};
                end
            end
        endcase
        if (w_load) begin
            w_tx_nx = r_hold_full ? r_hold : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_word_done <= 1'b0;
            miso        <= 1'b0;
            frame_err   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_tx_shift  <= w_tx_nx;
            r_rx_shift  <= w_rx_nx;
            r_word_done <= w_done_nx;
            miso        <= (w_state_nx == c_ACTIVE) && w_tx_bit_nx;
            frame_err   <= w_ferr_nx;
            underrun    <= w_load && !r_hold_full;
        end
    end

    // A capture in the same cycle as a load wins, so tx_ready stays low.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            overrun <= 1'b0;
            if (r_word_done) begin
                rx_data  <= r_rx_shift;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
// ============================================================================
// Module   : tb_spi_slave_ctrl
// Brief    : Directed bench for spi_slave_ctrl in mode 0 and mode 3.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       mosi = 1'b0;

    logic       sck0 = 1'b0, ssel0_ = 1'b1, rx_ack0 = 1'b0, tx_valid0 = 1'b0;
    logic [7:0] tx_data0 = '0;
    logic       miso0, rx_valid0, tx_ready0, busy0, frame_err0, overrun0, underrun0;
    logic [7:0] rx_data0;

    logic       sck3 = 1'b1, ssel3_ = 1'b1, rx_ack3 = 1'b0, tx_valid3 = 1'b0;
    logic [7:0] tx_data3 = '0;
    logic       miso3, rx_valid3, tx_ready3, busy3, frame_err3, overrun3, underrun3;
    logic [7:0] rx_data3;

    int n_chk = 0, n_err = 0;
    int und0 = 0, und3 = 0, ovr0 = 0, ferr0 = 0, ferr3 = 0;
    logic v_early, v_late;
    logic [7:0] mb;
    int base;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.WORD_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_(rst_), .sck(sck0), .mosi(mosi), .ssel_(ssel0_), .miso(miso0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(rx_ack0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0), .busy(busy0), .frame_err(frame_err0),
        .overrun(overrun0), .underrun(underrun0)
    );

    spi_slave_ctrl #(.WORD_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut3 (
        .clk(clk), .rst_(rst_), .sck(sck3), .mosi(mosi), .ssel_(ssel3_), .miso(miso3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ack(rx_ack3), .tx_data(tx_data3),
        .tx_valid(tx_valid3), .tx_ready(tx_ready3), .busy(busy3), .frame_err(frame_err3),
        .overrun(overrun3), .underrun(underrun3)
    );

    // Pulse-cycle counters, so one-cycle pulses can be checked afterwards.
    always @(posedge clk) begin
        if (underrun0)  und0  <= und0 + 1;
        if (underrun3)  und3  <= und3 + 1;
        if (overrun0)   ovr0  <= ovr0 + 1;
        if (frame_err0) ferr0 <= ferr0 + 1;
        if (frame_err3) ferr3 <= ferr3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: shifts the top n bits of w, MSB first, and returns the
    // miso bits seen just before each sample edge.
    task automatic send_bits(input bit m3, input logic [7:0] w, input int n,
                             output logic [7:0] bits);
        bits = '0;
        for (int i = 7; i > 7 - n; i--) begin
            if (m3) sck3 = 1'b0;
            mosi = w[i];
            wait_cyc(8);
            bits[i] = m3 ? miso3 : miso0;
            if (m3) sck3 = 1'b1; else sck0 = 1'b1;
            wait_cyc(3);
            v_early = m3 ? rx_valid3 : rx_valid0;
            wait_cyc(1);
            v_late = m3 ? rx_valid3 : rx_valid0;
            wait_cyc(4);
            if (!m3) sck0 = 1'b0;
        end
    endtask

    task automatic start_frame(input bit m3);
        if (m3) ssel3_ = 1'b0; else ssel0_ = 1'b0;
        wait_cyc(10);
    endtask

    task automatic end_frame(input bit m3);
        wait_cyc(8);
        if (m3) ssel3_ = 1'b1; else ssel0_ = 1'b1;
        wait_cyc(10);
    endtask

    task automatic ack0();
        rx_ack0 = 1'b1;
        wait_cyc(1);
        rx_ack0 = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_cyc(3);
        check("reset_flags", {miso0, rx_valid0, tx_ready0, busy0, frame_err0, overrun0, underrun0}, 7'b0010000);
        check("reset_rx_data", rx_data0, 8'h00);
        rst_ = 1'b1;
        wait_cyc(5);

        // Mode 0, no tx word offered: underrun, zeros out, receive 0xC8.
        base = und0;
        start_frame(0);
        check("m0_underrun_at_start", und0 - base, 1);
        check("m0_busy", busy0, 1'b1);
        send_bits(0, 8'hC8, 8, mb);
        check("m0_miso_zeros", mb, 8'h00);
        check("m0_latency_early", v_early, 1'b0);
        check("m0_latency_on_time", v_late, 1'b1);
        check("m0_rx_data", rx_data0, 8'hC8);
        base = ferr0;
        end_frame(0);
        check("m0_no_frame_err", ferr0 - base, 0);
        check("m0_idle_busy", busy0, 1'b0);
        ack0();
        check("m0_ack_clears", rx_valid0, 1'b0);

        // Mode 3 with 0xA5 preloaded, receive 0x3C.
        tx_data3 = 8'hA5;
        tx_valid3 = 1'b1;
        wait_cyc(1);
        tx_valid3 = 1'b0;
        wait_cyc(1);
        check("m3_tx_ready_full", tx_ready3, 1'b0);
        base = und3;
        start_frame(1);
        check("m3_tx_ready_after_load", tx_ready3, 1'b1);
        check("m3_no_underrun", und3 - base, 0);
        send_bits(1, 8'h3C, 8, mb);
        check("m3_miso", mb, 8'hA5);
        check("m3_rx_data", rx_data3, 8'h3C);
        check("m3_rx_valid", rx_valid3, 1'b1);
        base = ferr3;
        end_frame(1);
        check("m3_no_frame_err", ferr3 - base, 0);

        // Back-to-back words in one frame, then an overrun.
        base = ovr0;
        start_frame(0);
        send_bits(0, 8'h12, 8, mb);
        check("b2b_w1_data", rx_data0, 8'h12);
        check("b2b_w1_valid", rx_valid0, 1'b1);
        ack0();
        check("b2b_w1_ack", rx_valid0, 1'b0);
        send_bits(0, 8'h34, 8, mb);
        check("b2b_w2_data", rx_data0, 8'h34);
        check("b2b_w2_valid", rx_valid0, 1'b1);
        ack0();
        check("b2b_no_overrun", ovr0 - base, 0);
        send_bits(0, 8'h12, 8, mb);
        send_bits(0, 8'h34, 8, mb);
        check("ovr_pulse", ovr0 - base, 1);
        check("ovr_rx_data", rx_data0, 8'h34);
        check("ovr_rx_valid", rx_valid0, 1'b1);
        end_frame(0);

        // Abort after 5 bits with an unacknowledged word pending.
        base = ferr0;
        start_frame(0);
        send_bits(0, 8'hFF, 5, mb);
        end_frame(0);
        check("abort_frame_err_pulse", ferr0 - base, 1);
        check("abort_rx_valid_kept", rx_valid0, 1'b1);
        check("abort_rx_data_kept", rx_data0, 8'h34);
        ack0();
        start_frame(0);
        send_bits(0, 8'hFF, 8, mb);
        check("after_abort_rx_data", rx_data0, 8'hFF);
        end_frame(0);
        ack0();

        // Reset mid-frame, select held low through release.
        start_frame(0);
        send_bits(0, 8'hF0, 4, mb);
        rst_ = 1'b0;
        wait_cyc(2);
        check("midrst_flags", {miso0, rx_valid0, tx_ready0, busy0, frame_err0, overrun0, underrun0}, 7'b0010000);
        check("midrst_rx_data", rx_data0, 8'h00);
        rst_ = 1'b1;
        wait_cyc(5);
        send_bits(0, 8'h0F, 4, mb);
        check("midrst_no_restart", busy0, 1'b0);
        check("midrst_no_rx_valid", rx_valid0, 1'b0);
        ssel0_ = 1'b1;
        wait_cyc(10);
        start_frame(0);
        send_bits(0, 8'h5A, 8, mb);
        check("midrst_new_rx_data", rx_data0, 8'h5A);
        check("midrst_new_rx_valid", rx_valid0, 1'b1);
        end_frame(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
